my_counter_n: RTL and testbench

Parametrised, registered up/down counter with parallel load, generalising the 16-bit combinational incrementer into the stateful program-counter stage of the Hack CPU datapath. It holds a WIDTH-bit value that can be reset, loaded, stepped up or down by STEP, or held, each clock. It flags the cycle on which the count crosses its range boundary. The CPU uses it as the PC; the same block serves as a general timer/counter elsewhere.

---
 rtl/my_counter_n.sv | 82 ++++++++
 tb/tb_my_counter_n.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/my_counter_n.sv
// my_counter_n -- registered up/down counter with parallel load.
//
// Holds a WIDTH-bit count that is reset, loaded, stepped up or down by STEP,
// or held on each rising clk edge. The priority order is reset, then load,
// then a single step direction, then hold. The Hack CPU uses it as the
// program counter. It also serves as a general timer/counter.
//
// Build option:
//   MY_COUNTER_N_SATURATE_EN  when defined, a step past either end of the
//                             range clamps the count (all-ones or zero).
//                             When undefined, the count wraps modulo
//                             2^WIDTH. ovf pulses on that step in both modes.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high, highest priority
//   in     in   [WIDTH-1:0] parallel load value
//   load   in   load `in`; inc/dec ignored
//   inc    in   add STEP (only when dec is low)
//   dec    in   subtract STEP (only when inc is low)
//   out    out  [WIDTH-1:0] current count (register output)
//   ovf    out  one-cycle pulse: the step just taken crossed a range boundary
module my_counter_n #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STEP        = 1,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  // One extra bit holds the carry (increment) or the borrow (decrement).
  logic [WIDTH:0] sum, diff;
  assign sum  = {1'b0, out_q} + {1'b0, STEP_W};
  assign diff = {1'b0, out_q} - {1'b0, STEP_W};

  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    if (load) begin
      out_d = in;
    end else if (inc && !dec) begin
      out_d = sum[WIDTH-1:0];
      ovf_d = sum[WIDTH];
`ifdef MY_COUNTER_N_SATURATE_EN
      if (sum[WIDTH]) out_d = '1;
`endif
    end else if (dec && !inc) begin
      out_d = diff[WIDTH-1:0];
      ovf_d = diff[WIDTH];
`ifdef MY_COUNTER_N_SATURATE_EN
      if (diff[WIDTH]) out_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RST_W;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_my_counter_n.sv
// Scoreboard bench for my_counter_n. Three instances share the control
// inputs:
//   d0: WIDTH=16, STEP=1, RESET_VALUE=0
//   d1: WIDTH=8,  STEP=4, RESET_VALUE=0
//   d2: WIDTH=16, STEP=1, RESET_VALUE=0x0100
// The driver applies inputs at each negedge and queues the hand-computed
// results for the next posedge. The monitor pops all entries queued for an
// edge and compares them just after that edge.
module tb_my_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [15:0] in16 = '0;
  logic [7:0]  in8  = '0;
  logic [15:0] out0, out2;
  logic [7:0]  out1;
  logic        ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  my_counter_n #(.WIDTH(16), .STEP(1), .RESET_VALUE(32'h0)) d0 (
    .clk(clk), .reset(reset), .in(in16), .load(load), .inc(inc), .dec(dec),
    .out(out0), .ovf(ovf0));
  my_counter_n #(.WIDTH(8), .STEP(4), .RESET_VALUE(32'h0)) d1 (
    .clk(clk), .reset(reset), .in(in8), .load(load), .inc(inc), .dec(dec),
    .out(out1), .ovf(ovf1));
  my_counter_n #(.WIDTH(16), .STEP(1), .RESET_VALUE(32'h0100)) d2 (
    .clk(clk), .reset(reset), .in(in16), .load(load), .inc(inc), .dec(dec),
    .out(out2), .ovf(ovf2));

  typedef struct {
    int          id;
    logic [31:0] out;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic drive(input logic r, input logic ld, input logic ic, input logic dc,
                       input logic [15:0] v16, input logic [7:0] v8);
    @(negedge clk);
    reset = r; load = ld; inc = ic; dec = dc; in16 = v16; in8 = v8;
  endtask

  task automatic expect_(input int id, input logic [31:0] o, input logic v, input string nm);
    exp_t e;
    e.id = id; e.out = o; e.ovf = v; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation queued for the edge just taken.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] ao;
        logic        av;
        e = q.pop_front();
        case (e.id)
          0:       begin ao = {16'h0, out0}; av = ovf0; end
          1:       begin ao = {24'h0, out1}; av = ovf1; end
          default: begin ao = {16'h0, out2}; av = ovf2; end
        endcase
        n_checks++;
        if (ao !== e.out) begin
          n_fail++;
          $display("FAIL %s d%0d out: got %h expected %h", e.name, e.id, ao, e.out);
        end
        n_checks++;
        if (av !== e.ovf) begin
          n_fail++;
          $display("FAIL %s d%0d ovf: got %b expected %b", e.name, e.id, av, e.ovf);
        end
      end
    end
  end

  initial begin
    // Reset: every instance shows its RESET_VALUE.
    drive(1, 0, 0, 0, 16'h0, 8'h0);
    expect_(0, 32'h0000, 0, "reset");
    expect_(1, 32'h00,   0, "reset");
    expect_(2, 32'h0100, 0, "reset");

    // Count up from reset.
    drive(0, 0, 1, 0, 16'h0, 8'h0); expect_(0, 32'h0001, 0, "inc1");
    drive(0, 0, 1, 0, 16'h0, 8'h0); expect_(0, 32'h0002, 0, "inc2");
    drive(0, 0, 1, 0, 16'h0, 8'h0); expect_(0, 32'h0003, 0, "inc3");

    // Upper boundary.
    drive(0, 1, 0, 0, 16'hFFFE, 8'h0); expect_(0, 32'hFFFE, 0, "load_fffe");
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 0, "inc_to_max");
`ifdef MY_COUNTER_N_SATURATE_EN
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 1, "inc_ovf");
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 1, "inc_at_limit");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 0, "idle_after_ovf");
`else
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'h0000, 1, "inc_ovf");
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'h0001, 0, "inc_after_wrap");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(0, 32'h0001, 0, "idle_after_ovf");
`endif

    // Lower boundary.
    drive(0, 1, 0, 0, 16'h0000, 8'h0); expect_(0, 32'h0000, 0, "load_0");
`ifdef MY_COUNTER_N_SATURATE_EN
    drive(0, 0, 0, 1, 16'h0, 8'h0);    expect_(0, 32'h0000, 1, "dec_unf");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(0, 32'h0000, 0, "idle_after_unf");
`else
    drive(0, 0, 0, 1, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 1, "dec_unf");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 0, "idle_after_unf");
`endif

    // load beats inc; inc+dec together holds; plain dec.
    drive(0, 1, 1, 0, 16'h1234, 8'h0); expect_(0, 32'h1234, 0, "load_over_inc");
    drive(0, 0, 1, 1, 16'h0, 8'h0);    expect_(0, 32'h1234, 0, "inc_dec_hold");
    drive(0, 0, 0, 1, 16'h0, 8'h0);    expect_(0, 32'h1233, 0, "dec");

    // 8-bit, STEP=4 instance.
    drive(0, 1, 0, 0, 16'h0, 8'hFD);   expect_(1, 32'hFD, 0, "w8_load_fd");
`ifdef MY_COUNTER_N_SATURATE_EN
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(1, 32'hFF, 1, "w8_inc_ovf");
    drive(0, 0, 0, 1, 16'h0, 8'h0);    expect_(1, 32'hFB, 0, "w8_dec");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(1, 32'hFB, 0, "w8_idle");
`else
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(1, 32'h01, 1, "w8_inc_ovf");
    drive(0, 0, 0, 1, 16'h0, 8'h0);    expect_(1, 32'hFD, 1, "w8_dec_unf");
    drive(0, 0, 0, 0, 16'h0, 8'h0);    expect_(1, 32'hFD, 0, "w8_idle");
`endif

    // Raise ovf, then reset mid-sequence with load and inc both active.
    drive(0, 1, 0, 0, 16'hFFFF, 8'h0); expect_(0, 32'hFFFF, 0, "load_ffff");
`ifdef MY_COUNTER_N_SATURATE_EN
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'hFFFF, 1, "pre_reset_ovf");
`else
    drive(0, 0, 1, 0, 16'h0, 8'h0);    expect_(0, 32'h0000, 1, "pre_reset_ovf");
`endif
    drive(1, 1, 1, 0, 16'h5555, 8'h55);
    expect_(0, 32'h0000, 0, "mid_reset");
    expect_(1, 32'h00,   0, "mid_reset");
    expect_(2, 32'h0100, 0, "mid_reset");
    drive(0, 0, 1, 0, 16'h0, 8'h0);
    expect_(0, 32'h0001, 0, "resume_inc");
    expect_(2, 32'h0101, 0, "resume_inc");

    drive(0, 0, 0, 0, 16'h0, 8'h0);
    @(posedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
